riscv_reset_ctrl: RTL and testbench
===================================

# riscv_reset_ctrl

Reset sequencer that drives the active-low core reset of `RISCV_TOP`.
- Takes the board-level `CLK`/`RST` pair and synchronises reset deassertion.
- Stretches reset by a fixed hold window before releasing the core.
- Adds a software-requested reset path and a watchdog reset path.
- Reports the cause of the most recent reset to the core and to debug logic.

## Interface
Parameters:
- `SYNC_STAGES`, 2: reset-deassertion synchroniser depth (≥2).
- `HOLD_CYCLES`, 16: cycles the core is held in reset after synchronisation or after a soft pulse (≥1).
- `SOFT_PULSE`, 4: cycles of the soft/watchdog reset pulse before the hold window (≥1).
- `WDT_WIDTH`, 16: watchdog counter and limit width.

Ports:
- `CLK` in 1: the single clock; all state changes on its rising edge.
- `RST` in 1: asynchronous, active-low reset (0 = reset).
- `SOFT_REQ` in 1: level request for a soft core reset, sampled only in RUN.
- `WDT_EN` in 1: watchdog enable.
- `WDT_KICK` in 1: watchdog service strobe, one cycle.
- `WDT_LIMIT` in `WDT_WIDTH`: watchdog timeout in cycles; 0 disables expiry.
- `CORE_RST` out 1: active-low reset to `RISCV_TOP.RST`.
- `READY` out 1: 1 only in RUN.
- `SOFT_ACK` out 1: one-cycle pulse when a soft request is accepted.
- `RST_CAUSE` out 2: cause of the last reset; 00 power-on, 01 soft, 10 watchdog, 11 unused.

## Operation
- **States:** SYNC, HOLD, RUN, SOFT.
- **`RST`=0, asynchronous:**
  - State goes to SYNC.
  - Synchroniser flops, hold counter and watchdog counter clear to 0.
  - `CORE_RST`=0, `READY`=0, `SOFT_ACK`=0, `RST_CAUSE`=00.
- **SYNC:** a chain of `SYNC_STAGES` flops, async-cleared, shifts in 1. When the last stage is 1, go to HOLD with the hold counter at 0.
- **HOLD:** counts `HOLD_CYCLES` edges, then goes to RUN. `CORE_RST` and `READY` are registered high on that same edge.
- **RUN, per edge, in priority order:**
  1. **Watchdog expiry.** Condition: `WDT_EN`=1, `WDT_KICK`=0, `WDT_LIMIT`≠0 and count ≥ `WDT_LIMIT`−1.
     - Go to SOFT with `RST_CAUSE`←10.
     - `SOFT_ACK` is not pulsed, even if `SOFT_REQ`=1.
  2. **Soft request.** Condition: `SOFT_REQ`=1.
     - Go to SOFT with `RST_CAUSE`←01 and `SOFT_ACK`←1 for exactly one cycle.
  3. **Otherwise:** stay in RUN.
     - Watchdog count ←0 if `WDT_KICK`=1 or `WDT_EN`=0; otherwise count+1.
- **Watchdog count rules:**
  - Cleared on entry to RUN.
  - Never wraps: expiry fires first. If `WDT_LIMIT`=0, the count saturates at all-ones.
- **Entering SOFT:** `CORE_RST`←0 and `READY`←0 on the same edge.
- **SOFT:** counts `SOFT_PULSE` edges, then goes to HOLD with the hold counter at 0. The synchroniser is not re-run.
- **`RST_CAUSE` retention:** held until the next soft/watchdog entry, or until `RST`=0.
- **`SOFT_REQ` outside RUN:** ignored. If it is still high when RUN is re-entered, it is accepted again on the first RUN edge, giving back-to-back resets.

## Timing
- **Power-on latency:** `CORE_RST`/`READY` rise on rising edge number `SYNC_STAGES`+`HOLD_CYCLES`, counting the first edge that samples `RST`=1 as edge 1. With defaults this is edge 18.
- **Soft/watchdog latency:** the accept/expiry edge is edge k. `CORE_RST` falls at edge k and rises at edge k+`SOFT_PULSE`+`HOLD_CYCLES`, so it is low for 20 cycles with defaults.
- **`SOFT_ACK`:** high only during the cycle following edge k.
- **Watchdog timing:** with a constant `WDT_LIMIT`=L≠0 and no kicks, expiry is the L-th enabled RUN edge after entry to RUN or after the last kick.
  - A kick on what would be the expiry edge prevents expiry.
- **Asynchronous `RST` assertion:** `CORE_RST` falls without waiting for `CLK`, mid-SOFT or mid-HOLD included. It aborts every sequence and forces `RST_CAUSE`=00.
- **Output registration:** all outputs are registered; no combinational path from inputs to outputs.

## Test plan
1. **Power-on release:** `RST`=0 for 100 cycles, then 1 → `CORE_RST`=0, `READY`=0 through edge 17; both 1 from edge 18; `RST_CAUSE`=00.
2. **Soft reset:** in RUN, `SOFT_REQ`=1 for one cycle accepted at edge k → `SOFT_ACK` high for exactly one cycle; `CORE_RST` low from edge k to k+20; `RST_CAUSE`=01 afterwards.
3. **Watchdog expiry:** `WDT_EN`=1, `WDT_LIMIT`=5, no kicks → `CORE_RST` falls on the 5th RUN edge; `RST_CAUSE`=10; `SOFT_ACK` stays 0. Repeat with a kick every 4 cycles → no reset for 1000 cycles.
4. **Simultaneous events:** expiry edge with `SOFT_REQ`=1 → cause 10, no `SOFT_ACK`. With `SOFT_REQ` still high on RUN re-entry → accepted on the first RUN edge, cause 01, `SOFT_ACK` pulses.
5. **Reset mid-sequence:** drop `RST` to 0 at cycle 2 of SOFT and at cycle 7 of HOLD → `CORE_RST`=0 immediately; `RST_CAUSE`=00; full 18-edge power-on sequence on release.
6. **Watchdog disabled:** `WDT_LIMIT`=0 with `WDT_EN`=1 for 70000 cycles → no expiry; count saturates at 0xFFFF and does not wrap.

Source files
------------

// File: rtl/riscv_reset_ctrl.sv
// Reset sequencer for RISCV_TOP: synchronises board reset release, stretches it by a
// hold window, and adds soft-request and watchdog reset paths with cause reporting.
module riscv_reset_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int SOFT_PULSE  = 4,
  parameter int WDT_WIDTH   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SOFT_REQ,
  input  logic                 WDT_EN,
  input  logic                 WDT_KICK,
  input  logic [WDT_WIDTH-1:0] WDT_LIMIT,
  output logic                 CORE_RST,
  output logic                 READY,
  output logic                 SOFT_ACK,
  output logic [1:0]           RST_CAUSE
);

  localparam int CNT_MAX = (HOLD_CYCLES > SOFT_PULSE) ? HOLD_CYCLES : SOFT_PULSE;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_PULSE - 1);

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_SOFT = 2'b01;
  localparam logic [1:0] CAUSE_WDT  = 2'b10;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_HOLD,
    ST_RUN,
    ST_SOFT
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WDT_WIDTH-1:0]   wdt_q, wdt_d;
  logic                   core_rst_q, core_rst_d;
  logic                   ready_q, ready_d;
  logic                   soft_ack_q, soft_ack_d;
  logic [1:0]             cause_q, cause_d;
  logic                   wdt_expire;
  logic                   sync_done;

  // A kick on the would-be expiry edge wins over expiry.
  assign wdt_expire = WDT_EN && !WDT_KICK && (WDT_LIMIT != '0) &&
                      (wdt_q >= (WDT_LIMIT - WDT_WIDTH'(1)));

  // Leave SYNC on the edge where the last stage first captures a 1, so that
  // release lands on edge SYNC_STAGES + HOLD_CYCLES.
  assign sync_done = !sync_q[SYNC_STAGES-1] && sync_d[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], 1'b1};
    cnt_d      = cnt_q;
    wdt_d      = wdt_q;
    core_rst_d = core_rst_q;
    ready_d    = ready_q;
    soft_ack_d = 1'b0;
    cause_d    = cause_q;

    case (state_q)
      ST_SYNC: begin
        if (sync_done) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end

      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d    = ST_RUN;
          cnt_d      = '0;
          wdt_d      = '0;
          core_rst_d = 1'b1;
          ready_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (wdt_expire) begin
          state_d    = ST_SOFT;
          cnt_d      = '0;
          core_rst_d = 1'b0;
          ready_d    = 1'b0;
          cause_d    = CAUSE_WDT;
        end else if (SOFT_REQ) begin
          state_d    = ST_SOFT;
          cnt_d      = '0;
          core_rst_d = 1'b0;
          ready_d    = 1'b0;
          soft_ack_d = 1'b1;
          cause_d    = CAUSE_SOFT;
        end else if (WDT_KICK || !WDT_EN) begin
          wdt_d = '0;
        end else if (!(&wdt_q)) begin
          wdt_d = wdt_q + WDT_WIDTH'(1);
        end
      end

      ST_SOFT: begin
        if (cnt_q == SOFT_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_SYNC;
      sync_q     <= '0;
      cnt_q      <= '0;
      wdt_q      <= '0;
      core_rst_q <= 1'b0;
      ready_q    <= 1'b0;
      soft_ack_q <= 1'b0;
      cause_q    <= CAUSE_POR;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      wdt_q      <= wdt_d;
      core_rst_q <= core_rst_d;
      ready_q    <= ready_d;
      soft_ack_q <= soft_ack_d;
      cause_q    <= cause_d;
    end
  end

  assign CORE_RST  = core_rst_q;
  assign READY     = ready_q;
  assign SOFT_ACK  = soft_ack_q;
  assign RST_CAUSE = cause_q;

endmodule

// File: tb/tb_riscv_reset_ctrl.sv
// Bench for riscv_reset_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a countdown-style reference model.
module tb_riscv_reset_ctrl;

  localparam int SS = 2;
  localparam int HC = 16;
  localparam int SP = 4;
  localparam int WW = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          SOFT_REQ = 1'b0;
  logic          WDT_EN = 1'b0;
  logic          WDT_KICK = 1'b0;
  logic [WW-1:0] WDT_LIMIT = '0;
  logic          CORE_RST;
  logic          READY;
  logic          SOFT_ACK;
  logic [1:0]    RST_CAUSE;

  riscv_reset_ctrl #(
    .SYNC_STAGES(SS),
    .HOLD_CYCLES(HC),
    .SOFT_PULSE (SP),
    .WDT_WIDTH  (WW)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .SOFT_REQ (SOFT_REQ),
    .WDT_EN   (WDT_EN),
    .WDT_KICK (WDT_KICK),
    .WDT_LIMIT(WDT_LIMIT),
    .CORE_RST (CORE_RST),
    .READY    (READY),
    .SOFT_ACK (SOFT_ACK),
    .RST_CAUSE(RST_CAUSE)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: the core is either running, or waiting m_down more edges
  // before it is released; the watchdog is a plain saturating integer.
  bit       m_run   = 1'b0;
  int       m_down  = SS + HC;
  int       m_wdt   = 0;
  bit       m_ack   = 1'b0;
  bit [1:0] m_cause = 2'b00;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_run   <= 1'b0;
      m_down  <= SS + HC;
      m_wdt   <= 0;
      m_ack   <= 1'b0;
      m_cause <= 2'b00;
    end else if (!m_run) begin
      m_ack <= 1'b0;
      if (m_down == 1) begin
        m_run  <= 1'b1;
        m_down <= 0;
        m_wdt  <= 0;
      end else begin
        m_down <= m_down - 1;
      end
    end else if (WDT_EN && !WDT_KICK && WDT_LIMIT != 0 && m_wdt >= int'(WDT_LIMIT) - 1) begin
      m_run   <= 1'b0;
      m_down  <= SP + HC;
      m_cause <= 2'b10;
      m_ack   <= 1'b0;
    end else if (SOFT_REQ) begin
      m_run   <= 1'b0;
      m_down  <= SP + HC;
      m_cause <= 2'b01;
      m_ack   <= 1'b1;
    end else begin
      m_ack <= 1'b0;
      if (WDT_KICK || !WDT_EN) m_wdt <= 0;
      else if (m_wdt < (1 << WW) - 1) m_wdt <= m_wdt + 1;
    end
  end

  always @(negedge CLK) begin
    chk("cmp_core_rst", {31'd0, CORE_RST}, {31'd0, m_run});
    chk("cmp_ready", {31'd0, READY}, {31'd0, m_run});
    chk("cmp_soft_ack", {31'd0, SOFT_ACK}, {31'd0, m_ack});
    chk("cmp_cause", {30'd0, RST_CAUSE}, {30'd0, m_cause});
  end

  // All directed tasks leave the bench 1 time unit after a rising edge.
  task automatic wait_ready(input string nm, input int budget);
    int n = 0;
    while (!READY && n < budget) begin
      @(posedge CLK); #1;
      n++;
    end
    chk(nm, {31'd0, READY}, 32'd1);
  endtask

  task automatic power_on(input string tag);
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    for (int e = 1; e <= SS + HC; e++) begin
      @(posedge CLK); #1;
      if (e == 17) begin
        chk({tag, "_core_edge17"}, {31'd0, CORE_RST}, 32'd0);
        chk({tag, "_ready_edge17"}, {31'd0, READY}, 32'd0);
      end
    end
    chk({tag, "_core_edge18"}, {31'd0, CORE_RST}, 32'd1);
    chk({tag, "_ready_edge18"}, {31'd0, READY}, 32'd1);
    chk({tag, "_cause_por"}, {30'd0, RST_CAUSE}, 32'd0);
  endtask

  task automatic soft_reset(input string tag);
    int n = 0;
    SOFT_REQ = 1'b1;
    @(posedge CLK); #1;
    SOFT_REQ = 1'b0;
    chk({tag, "_core_fall"}, {31'd0, CORE_RST}, 32'd0);
    chk({tag, "_ack_hi"}, {31'd0, SOFT_ACK}, 32'd1);
    chk({tag, "_cause_soft"}, {30'd0, RST_CAUSE}, 32'd1);
    while (!CORE_RST && n < 100) begin
      @(posedge CLK); #1;
      n++;
      if (n == 1) chk({tag, "_ack_lo"}, {31'd0, SOFT_ACK}, 32'd0);
    end
    chk({tag, "_low_edges"}, n, 32'd20);
  endtask

  initial begin
    int  n;
    bit  fell;
    int  lims [5] = '{0, 1, 3, 8, 25};

    #1 RST = 1'b0;
    #3;
    chk("reset_core", {31'd0, CORE_RST}, 32'd0);
    chk("reset_ready", {31'd0, READY}, 32'd0);
    chk("reset_cause", {30'd0, RST_CAUSE}, 32'd0);
    repeat (100) @(posedge CLK);

    power_on("por");
    soft_reset("soft");

    // Watchdog expiry with limit 5 and no kicks.
    WDT_LIMIT = 16'd5;
    WDT_EN    = 1'b1;
    n = 0;
    while (CORE_RST && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("wdt_expiry_edge", n, 32'd5);
    chk("wdt_cause", {30'd0, RST_CAUSE}, 32'd2);
    chk("wdt_no_ack", {31'd0, SOFT_ACK}, 32'd0);
    wait_ready("wdt_recover", 40);

    fell = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      WDT_KICK = (i % 4 == 0);
      @(posedge CLK); #1;
      if (!CORE_RST) fell = 1'b1;
    end
    WDT_KICK = 1'b0;
    chk("wdt_kicked_no_reset", {31'd0, fell}, 32'd0);
    WDT_EN = 1'b0;

    // Expiry and soft request on the same edge, then re-acceptance on RUN re-entry.
    @(posedge CLK); #1;
    WDT_EN = 1'b1;
    repeat (4) begin
      @(posedge CLK); #1;
    end
    SOFT_REQ = 1'b1;
    @(posedge CLK); #1;
    chk("simul_core_fall", {31'd0, CORE_RST}, 32'd0);
    chk("simul_cause_wdt", {30'd0, RST_CAUSE}, 32'd2);
    chk("simul_no_ack", {31'd0, SOFT_ACK}, 32'd0);
    wait_ready("simul_reentry", 40);
    @(posedge CLK); #1;
    chk("reentry_core_fall", {31'd0, CORE_RST}, 32'd0);
    chk("reentry_ack", {31'd0, SOFT_ACK}, 32'd1);
    chk("reentry_cause", {30'd0, RST_CAUSE}, 32'd1);
    SOFT_REQ = 1'b0;
    WDT_EN   = 1'b0;
    wait_ready("reentry_recover", 40);

    // Board reset during SOFT (second cycle).
    SOFT_REQ = 1'b1;
    @(posedge CLK); #1;
    SOFT_REQ = 1'b0;
    @(posedge CLK); #2;
    chk("midsoft_cause_before", {30'd0, RST_CAUSE}, 32'd1);
    RST = 1'b0;
    #1;
    chk("midsoft_core", {31'd0, CORE_RST}, 32'd0);
    chk("midsoft_cause", {30'd0, RST_CAUSE}, 32'd0);
    power_on("midsoft");

    // Board reset during HOLD (seventh cycle).
    WDT_LIMIT = 16'd3;
    WDT_EN    = 1'b1;
    repeat (3 + SP + 7) @(posedge CLK);
    #2;
    chk("midhold_core_before", {31'd0, CORE_RST}, 32'd0);
    chk("midhold_cause_before", {30'd0, RST_CAUSE}, 32'd2);
    RST = 1'b0;
    #1;
    chk("midhold_core", {31'd0, CORE_RST}, 32'd0);
    chk("midhold_cause", {30'd0, RST_CAUSE}, 32'd0);
    WDT_EN = 1'b0;
    power_on("midhold");

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK); #2;
      if (!RST) begin
        if ($urandom_range(0, 3) == 0) RST = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        RST = 1'b0;
      end
      if (i % 200 == 0) WDT_LIMIT = WW'(lims[$urandom_range(0, 4)]);
      SOFT_REQ = ($urandom_range(0, 49) == 0);
      WDT_EN   = ($urandom_range(0, 7) != 0);
      WDT_KICK = ($urandom_range(0, 9) == 0);
    end
    RST      = 1'b1;
    SOFT_REQ = 1'b0;
    WDT_EN   = 1'b0;
    WDT_KICK = 1'b0;
    wait_ready("rand_recover", 60);

    // Limit 0 never expires; the count must saturate rather than wrap.
    WDT_LIMIT = '0;
    WDT_EN    = 1'b1;
    fell = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(posedge CLK); #1;
      if (!CORE_RST) fell = 1'b1;
    end
    chk("wdt_disabled_no_reset", {31'd0, fell}, 32'd0);
    WDT_LIMIT = 16'hFFFF;
    @(posedge CLK); #1;
    chk("wdt_saturated_expiry", {31'd0, CORE_RST}, 32'd0);
    chk("wdt_saturated_cause", {30'd0, RST_CAUSE}, 32'd2);
    WDT_EN = 1'b0;
    wait_ready("final_recover", 40);

    repeat (2) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
